// File: rtl/branch_resolve_unit.sv
// Pipelined conditional-branch resolution stage: decode, compare, target/next-PC
// computation and illegal/misaligned flags behind valid/ready handshakes.
package branch_resolve_pkg;
    typedef enum logic [2:0] {
        bk_beq     = 3'd0,
        bk_bne     = 3'd1,
        bk_blt     = 3'd2,
        bk_bge     = 3'd3,
        bk_bltu    = 3'd4,
        bk_bgeu    = 3'd5,
        bk_invalid = 3'd6
    } branch_kind_t;
endpackage

module branch_resolve_unit
    import branch_resolve_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int RVC    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    output logic             out_valid,
    input  logic             out_ready,
    output branch_kind_t     kind,
    output logic             taken,
    output logic [XLEN-1:0]  target,
    output logic [XLEN-1:0]  next_pc,
    output logic             illegal,
    output logic             misaligned
);

    if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
        $error("branch_resolve_unit: STAGES must be 1 or 2");
    end

    function automatic branch_kind_t decode_kind(input logic [2:0] f);
        case (f)
            3'b000:  decode_kind = bk_beq;
            3'b001:  decode_kind = bk_bne;
            3'b100:  decode_kind = bk_blt;
            3'b101:  decode_kind = bk_bge;
            3'b110:  decode_kind = bk_bltu;
            3'b111:  decode_kind = bk_bgeu;
            default: decode_kind = bk_invalid;
        endcase
    endfunction

    function automatic logic resolve(input branch_kind_t k,
                                     input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        case (k)
            bk_beq:  resolve = (a == b);
            bk_bne:  resolve = (a != b);
            bk_blt:  resolve = ($signed(a) <  $signed(b));
            bk_bge:  resolve = ($signed(a) >= $signed(b));
            bk_bltu: resolve = (a <  b);
            bk_bgeu: resolve = (a >= b);
            default: resolve = 1'b0;
        endcase
    endfunction

    // Inputs of the final (output) stage, fed either by stage A or directly by the ports.
    logic            s_valid;
    branch_kind_t    s_kind;
    logic            s_taken;
    logic [XLEN-1:0] s_pc;
    logic [XLEN-1:0] s_imm;
    logic            last_load;

    assign last_load = !out_valid || out_ready;

    if (STAGES == 2) begin : g_two
        logic            a_valid;
        branch_kind_t    a_kind;
        logic            a_taken;
        logic [XLEN-1:0] a_pc;
        logic [XLEN-1:0] a_imm;
        logic            a_load;

        assign a_load   = !a_valid || last_load;
        assign in_ready = a_load;

        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                a_valid <= 1'b0;
            else if (flush)
                a_valid <= 1'b0;
            else if (a_load)
                a_valid <= in_valid;
        end

        // NOTE: payload is not reset; it is only meaningful while a_valid is set.
        always_ff @(posedge clk) begin
            if (a_load && in_valid) begin
                a_kind  <= decode_kind(funct3);
                a_taken <= resolve(decode_kind(funct3), rs1, rs2);
                a_pc    <= pc;
                a_imm   <= imm;
            end
        end

        assign s_valid = a_valid;
        assign s_kind  = a_kind;
        assign s_taken = a_taken;
        assign s_pc    = a_pc;
        assign s_imm   = a_imm;
    end else begin : g_one
        assign in_ready = last_load;
        assign s_valid  = in_valid;
        assign s_kind   = decode_kind(funct3);
        assign s_taken  = resolve(decode_kind(funct3), rs1, rs2);
        assign s_pc     = pc;
        assign s_imm    = imm;
    end

    logic [XLEN-1:0] s_target;
    logic [XLEN-1:0] s_next_pc;
    logic            s_misaligned;

    assign s_target     = s_pc + s_imm;
    assign s_next_pc    = s_taken ? s_target : s_pc + XLEN'(4);
    assign s_misaligned = s_taken && ((RVC != 0) ? s_target[0] : (|s_target[1:0]));

    // Output registers reset to defined values, so they share the async-reset block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            kind       <= bk_invalid;
            taken      <= 1'b0;
            target     <= '0;
            next_pc    <= '0;
            illegal    <= 1'b0;
            misaligned <= 1'b0;
        end else if (flush) begin
            out_valid  <= 1'b0;
        end else if (last_load) begin
            out_valid <= s_valid;
            if (s_valid) begin
                kind       <= s_kind;
                taken      <= s_taken;
                target     <= s_target;
                next_pc    <= s_next_pc;
                illegal    <= (s_kind == bk_invalid);
                misaligned <= s_misaligned;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: a 2-stage RVC=0 unit and a 1-stage RVC=1 unit fed the same accepted ops,
// each checked against a behavioural branch model.
module tb_branch_resolve_unit;
    import branch_resolve_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [2:0]  funct3;
    logic [31:0] pc, imm, rs1, rs2;
    logic        out_ready;

    logic         in_ready0, out_valid0, taken0, illegal0, misaligned0;
    branch_kind_t kind0;
    logic [31:0]  target0, next_pc0;

    logic         in_valid1, in_ready1, out_valid1, taken1, illegal1, misaligned1;
    branch_kind_t kind1;
    logic [31:0]  target1, next_pc1;

    always #5 clk = ~clk;

    // The 1-stage unit sees exactly the ops the 2-stage unit accepts.
    assign in_valid1 = in_valid & in_ready0;

    branch_resolve_unit #(.XLEN(32), .STAGES(2), .RVC(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .funct3(funct3), .pc(pc), .imm(imm), .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid0), .out_ready(out_ready), .kind(kind0), .taken(taken0),
        .target(target0), .next_pc(next_pc0), .illegal(illegal0), .misaligned(misaligned0)
    );

    branch_resolve_unit #(.XLEN(32), .STAGES(1), .RVC(1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid1), .in_ready(in_ready1),
        .funct3(funct3), .pc(pc), .imm(imm), .rs1(rs1), .rs2(rs2),
        .out_valid(out_valid1), .out_ready(1'b1), .kind(kind1), .taken(taken1),
        .target(target1), .next_pc(next_pc1), .illegal(illegal1), .misaligned(misaligned1)
    );

    typedef struct {
        branch_kind_t kind;
        logic         taken;
        logic [31:0]  target;
        logic [31:0]  next_pc;
        logic         illegal;
        logic         misaligned;
        int           acc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   errors = 0;
    int   checks = 0;
    int   cycle  = 0;

    logic [69:0] res0, res1;
    assign res0 = {kind0, taken0, target0, next_pc0, illegal0, misaligned0};
    assign res1 = {kind1, taken1, target1, next_pc1, illegal1, misaligned1};

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    // Reference behaviour straight from the branch rules.
    function automatic exp_t model(input logic [2:0] f, input logic [31:0] p, input logic [31:0] im,
                                   input logic [31:0] a, input logic [31:0] b, input bit rvc);
        exp_t e;
        e.taken = 1'b0;
        case (f)
            3'd0: begin e.kind = bk_beq;  e.taken = (a == b); end
            3'd1: begin e.kind = bk_bne;  e.taken = (a != b); end
            3'd4: begin e.kind = bk_blt;  e.taken = (int'(a) <  int'(b)); end
            3'd5: begin e.kind = bk_bge;  e.taken = (int'(a) >= int'(b)); end
            3'd6: begin e.kind = bk_bltu; e.taken = (longint'(a) <  longint'(b)); end
            3'd7: begin e.kind = bk_bgeu; e.taken = (longint'(a) >= longint'(b)); end
            default: e.kind = bk_invalid;
        endcase
        e.illegal    = (f == 3'd2) || (f == 3'd3);
        e.target     = p + im;
        e.next_pc    = e.taken ? e.target : p + 32'd4;
        e.misaligned = e.taken && (rvc ? (e.target % 2 != 0) : (e.target % 4 != 0));
        e.acc        = cycle;
        return e;
    endfunction

    function automatic logic [69:0] pack_exp(input exp_t e);
        return {e.kind, e.taken, e.target, e.next_pc, e.illegal, e.misaligned};
    endfunction

    // Occupancy = queued ops; the head must reach the output exactly STAGES cycles after acceptance.
    task automatic sb_step(input int d, input logic ov, input logic ordy, input logic ir,
                           input logic [69:0] res, input int stages);
        int    n;
        exp_t  head;
        string pre;
        pre = (d == 0) ? "s2" : "s1";
        n   = (d == 0) ? q0.size() : q1.size();
        check({pre, "_in_ready"}, ir, (n < stages) || ordy);
        if (n > 0) head = (d == 0) ? q0[0] : q1[0];
        check({pre, "_out_valid"}, ov, (n > 0) && (cycle - head.acc >= stages));
        if (ov && n > 0) begin
            check({pre, "_result"}, res, pack_exp(head));
            if (ordy) begin
                if (d == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
            end
        end
    endtask

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            sb_step(0, out_valid0, out_ready, in_ready0, res0, 2);
            sb_step(1, out_valid1, 1'b1, in_ready1, res1, 1);
            if (flush) begin
                q0.delete();
                q1.delete();
            end else if (in_valid && in_ready0) begin
                q0.push_back(model(funct3, pc, imm, rs1, rs2, 1'b0));
                q1.push_back(model(funct3, pc, imm, rs1, rs2, 1'b1));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the op was accepted, in_valid still high.
    task automatic issue(input logic [2:0] f, input logic [31:0] p, input logic [31:0] im,
                         input logic [31:0] a, input logic [31:0] b);
        int waited;
        bit acc;
        funct3 = f; pc = p; imm = im; rs1 = a; rs2 = b; in_valid = 1'b1;
        waited = 0;
        acc    = 1'b0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready0;
            @(posedge clk);
            #1;
            waited++;
            if (!acc && waited > 100) begin
                checks++;
                errors++;
                $display("FAIL issue_timeout @%0t: in_ready stayed low for %0d cycles", $time, waited);
                acc = 1'b1;
            end
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    bit rand_done;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        funct3 = '0; pc = '0; imm = '0; rs1 = '0; rs2 = '0;
        rand_done = 1'b0;

        #3;
        check("rst_out_valid", out_valid0, 0);
        check("rst_kind", kind0, bk_invalid);
        check("rst_flags", {taken0, illegal0, misaligned0}, 0);
        check("rst_target", target0, 0);
        check("rst_next_pc", next_pc0, 0);
        check("rst_s1_out_valid", out_valid1, 0);
        check("rst_s1_kind", kind1, bk_invalid);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic BEQ, signed vs unsigned, illegal, misaligned BNE, PC wrap.
        issue(3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
        idle(); settle(4);
        issue(3'b100, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1);
        issue(3'b110, 32'h204, 32'h10, 32'hFFFF_FFFF, 32'd1);
        issue(3'b011, 32'h208, 32'h40, 32'd1, 32'd1);
        issue(3'b001, 32'h300, 32'h2, 32'd1, 32'd2);
        issue(3'b000, 32'hFFFF_FFFC, 32'h8, 32'd7, 32'd7);
        idle(); settle(4);

        // Backpressure: six back-to-back ops, out_ready low for four cycles.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    issue(3'(i % 2 == 0 ? 3'b101 : 3'b111), 32'h400 + 32'(4 * i), 32'h80,
                          32'(i), 32'd3);
                idle();
            end
            begin
                settle(2);
                out_ready = 1'b0;
                settle(4);
                out_ready = 1'b1;
            end
        join
        settle(4);

        // Flush with both stages full and a third op presented.
        out_ready = 1'b0;
        issue(3'b000, 32'h500, 32'h10, 32'd1, 32'd1);
        issue(3'b001, 32'h504, 32'h10, 32'd1, 32'd2);
        issue_present: begin
            funct3 = 3'b100; pc = 32'h508; imm = 32'h10; rs1 = 32'd0; rs2 = 32'd1;
            in_valid = 1'b1;
            flush = 1'b1;
        end
        settle(1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("flush_out_valid", out_valid0, 0);
            check("flush_s1_out_valid", out_valid1, 0);
        end
        settle(1);

        // Asynchronous reset between edges with ops in flight.
        issue(3'b000, 32'h600, 32'h10, 32'd9, 32'd9);
        issue(3'b101, 32'h604, 32'h10, 32'd9, 32'd2);
        idle();
        #1;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid0, 0);
        check("arst_kind", kind0, bk_invalid);
        check("arst_s1_out_valid", out_valid1, 0);
        check("arst_s1_kind", kind1, bk_invalid);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(3'b110, 32'h700, 32'hFFFF_FFF0, 32'd1, 32'd2);
        idle(); settle(4);

        // Randomised traffic with random backpressure and occasional flushes.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [31:0] a, b, r;
                    if ($urandom_range(0, 3) == 0) begin
                        idle();
                        settle($urandom_range(1, 3));
                    end
                    a = $urandom;
                    r = $urandom;
                    case ($urandom_range(0, 3))
                        0:       b = a;
                        1:       b = a ^ 32'h8000_0000;
                        default: b = $urandom;
                    endcase
                    issue(3'($urandom_range(0, 7)), $urandom,
                          ($urandom_range(0, 1) != 0) ? {{20{r[11]}}, r[11:0]} : r, a, b);
                end
                idle();
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    flush     = ($urandom_range(0, 40) == 0);
                end
            end
        join
        out_ready = 1'b1;
        flush     = 1'b0;
        idle();
        settle(10);
        check("s2_drained", q0.size(), 0);
        check("s1_drained", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
